// File: rtl/imo_pkg.sv
// Shared IMO definitions: instruction field positions, opcodes, FSM state type
// and the opcode classifier used to decide whether a response will come back.
package imo_pkg;

  localparam int IMO_INST_W  = 128;
  localparam int IMO_DATA_W  = 512;
  localparam int IMO_OPC_MSB = 127;
  localparam int IMO_OPC_LSB = 124;

  localparam logic [3:0] IMO_OPC_RNG_RD  = 4'h1;
  localparam logic [3:0] IMO_OPC_CR_WR   = 4'h2;
  localparam logic [3:0] IMO_OPC_DATA_RD = 4'h3;
  localparam logic [3:0] IMO_OPC_COPY    = 4'h4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } imo_state_e;

  function automatic logic imo_needs_resp(input logic [3:0] opcode);
    return (opcode == IMO_OPC_RNG_RD) || (opcode == IMO_OPC_DATA_RD);
  endfunction

endpackage

// File: rtl/imo_requester_if.sv
// Requester <-> memory controller IMO bus: request valid/ack handshake and
// the one-cycle, non-backpressured response strobe.
interface imo_requester_if;
  import imo_pkg::*;

  logic                  imo_req_valid;
  logic                  imo_req_ack;
  logic [IMO_INST_W-1:0] imo_req_inst;
  logic [IMO_DATA_W-1:0] imo_resp_data;
  logic                  imo_resp_valid;

  modport master (
    output imo_req_valid, imo_req_inst,
    input  imo_req_ack, imo_resp_data, imo_resp_valid
  );

  modport slave (
    input  imo_req_valid, imo_req_inst,
    output imo_req_ack, imo_resp_data, imo_resp_valid
  );
endinterface

// File: rtl/imo_cmd_fifo.sv
// Command FIFO: register-based storage with the head entry presented directly,
// count-based full/empty. Push is ignored when full, pop when empty.
module imo_cmd_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/imo_requester.sv
// IMO initiator: queues core commands, issues them to the memory controller one
// at a time and holds at most one response for the core.
module imo_requester
  import imo_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [IMO_INST_W-1:0] cmd_inst,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IMO_DATA_W-1:0] rsp_data,
  imo_requester_if.master       imo,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_unsolicited,
  input  logic                  err_clr,
  output logic [31:0]           issued_cnt
);
  localparam int             TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  imo_state_e            state;
  logic [TMR_W-1:0]      timer;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [IMO_INST_W-1:0] fifo_dout;
  logic                  push;
  logic                  pop;
  logic                  head_needs_resp;
  logic                  req_needs_resp;

  assign cmd_ready       = !fifo_full;
  assign push            = cmd_valid && !fifo_full;
  assign head_needs_resp = imo_needs_resp(fifo_dout[IMO_OPC_MSB:IMO_OPC_LSB]);
  assign req_needs_resp  = imo_needs_resp(imo.imo_req_inst[IMO_OPC_MSB:IMO_OPC_LSB]);
  // A response-bearing head waits while the core still holds a response.
  assign pop             = (state == IDLE) && !fifo_empty && (!head_needs_resp || !rsp_valid);
  assign busy            = !fifo_empty || (state != IDLE);

  imo_cmd_fifo #(
    .WIDTH (IMO_INST_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cmd_inst),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      timer             <= '0;
      imo.imo_req_valid <= 1'b0;
      imo.imo_req_inst  <= '0;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      err_timeout       <= 1'b0;
      err_unsolicited   <= 1'b0;
      issued_cnt        <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      // Anything outside WAIT_RESP is dropped, including an ack-cycle response.
      if (imo.imo_resp_valid && (state != WAIT_RESP)) err_unsolicited <= 1'b1;

      unique case (state)
        IDLE: begin
          if (pop) begin
            imo.imo_req_inst  <= fifo_dout;
            imo.imo_req_valid <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          if (imo.imo_req_ack) begin
            issued_cnt        <= issued_cnt + 32'd1;
            imo.imo_req_valid <= 1'b0;
            timer             <= '0;
            state             <= req_needs_resp ? WAIT_RESP : IDLE;
          end
        end
        WAIT_RESP: begin
          if (imo.imo_resp_valid) begin
            rsp_data  <= imo.imo_resp_data;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else if (timer == TMR_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (err_clr) begin
        err_timeout     <= 1'b0;
        err_unsolicited <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imo_requester.sv
// Directed bench for imo_requester: cycle vector table for the basic flows,
// hand-written sequences for backpressure, blocking, timeout and reset.
module tb_imo_requester;
  import imo_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [127:0] cmd_inst;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [511:0] rsp_data;
  logic         busy;
  logic         err_timeout;
  logic         err_unsolicited;
  logic         err_clr;
  logic [31:0]  issued_cnt;

  imo_requester_if bus();

  imo_requester #(
    .CMD_DEPTH   (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_inst        (cmd_inst),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .imo             (bus),
    .busy            (busy),
    .err_timeout     (err_timeout),
    .err_unsolicited (err_unsolicited),
    .err_clr         (err_clr),
    .issued_cnt      (issued_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] DATA_A5 = {64{8'hA5}};
  localparam logic [511:0] DATA_X1 = {64{8'h3C}};
  localparam logic [511:0] DATA_X2 = {16{32'h1234_5678}};
  localparam logic [127:0] INST_CR = {4'h2, 124'h5};
  localparam logic [127:0] INST_RR = {4'h1, 124'h77};

  typedef struct {
    logic         cv;
    logic [127:0] ci;
    logic         rr;
    logic         ack;
    logic         rv;
    logic         ec;
    logic         e_req;
    logic [127:0] e_inst;
    logic         e_rsp;
    logic [511:0] e_rdata;
    logic         e_cr;
    logic         e_busy;
    logic         e_et;
    logic         e_eu;
    logic [31:0]  e_cnt;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 0;

  function automatic vec_t mk(input logic cv, input logic [127:0] ci, input logic rr,
                              input logic ack, input logic rv, input logic ec,
                              input logic e_req, input logic [127:0] e_inst,
                              input logic e_rsp, input logic e_busy, input logic e_eu,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.cv = cv; v.ci = ci; v.rr = rr; v.ack = ack; v.rv = rv; v.ec = ec;
    v.e_req = e_req; v.e_inst = e_inst; v.e_rsp = e_rsp;
    v.e_rdata = DATA_A5; v.e_cr = 1'b1; v.e_busy = e_busy;
    v.e_et = 1'b0; v.e_eu = e_eu; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [127:0] inst);
    cmd_valid = 1'b1;
    cmd_inst  = inst;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.imo_req_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, ".req_seen"}, bus.imo_req_valid, 1'b1);
  endtask

  task automatic ack_req(input logic [127:0] inst, input string name);
    wait_req(name);
    chk({name, ".inst"}, bus.imo_req_inst, inst);
    bus.imo_req_ack = 1'b1;
    tick();
    bus.imo_req_ack = 1'b0;
    exp_cnt++;
    chk({name, ".cnt"}, issued_cnt, exp_cnt);
    chk({name, ".req_drop"}, bus.imo_req_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [127:0] f[6];
    logic        saw_req;

    rst_n = 1'b1; cmd_valid = 1'b0; cmd_inst = '0; rsp_ready = 1'b0; err_clr = 1'b0;
    bus.imo_req_ack = 1'b0; bus.imo_resp_valid = 1'b0; bus.imo_resp_data = '0;
    #1 rst_n = 1'b0;
    tick();
    chk("rst.cmd_ready", cmd_ready, 1'b1);
    chk("rst.req_valid", bus.imo_req_valid, 1'b0);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.errs", {err_timeout, err_unsolicited}, 2'b00);
    chk("rst.cnt", issued_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    // CR_WR with ack after 3 cycles of valid, then RNG_RD with a response 10 cycles after ack.
    tbl.push_back(mk(1, INST_CR, 0, 0, 0, 0, 0, INST_CR, 0, 1, 0, 0));
    tbl.push_back(mk(0, '0,      0, 0, 0, 0, 1, INST_CR, 0, 1, 0, 0));
    tbl.push_back(mk(0, '0,      0, 0, 0, 0, 1, INST_CR, 0, 1, 0, 0));
    tbl.push_back(mk(0, '0,      0, 0, 0, 0, 1, INST_CR, 0, 1, 0, 0));
    tbl.push_back(mk(0, '0,      0, 1, 0, 0, 0, INST_CR, 0, 0, 0, 1));
    tbl.push_back(mk(0, '0,      0, 0, 0, 0, 0, INST_CR, 0, 0, 0, 1));
    tbl.push_back(mk(1, INST_RR, 0, 0, 0, 0, 0, INST_RR, 0, 1, 0, 1));
    tbl.push_back(mk(0, '0,      0, 0, 0, 0, 1, INST_RR, 0, 1, 0, 1));
    tbl.push_back(mk(0, '0,      0, 1, 0, 0, 0, INST_RR, 0, 1, 0, 2));
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(0, '0,    0, 0, 0, 0, 0, INST_RR, 0, 1, 0, 2));
    tbl.push_back(mk(0, '0,      0, 0, 1, 0, 0, INST_RR, 1, 0, 0, 2));
    tbl.push_back(mk(0, '0,      0, 0, 0, 0, 0, INST_RR, 1, 0, 0, 2));
    tbl.push_back(mk(0, '0,      1, 0, 0, 0, 0, INST_RR, 0, 0, 0, 2));
    tbl.push_back(mk(0, '0,      0, 0, 1, 0, 0, INST_RR, 0, 0, 1, 2));
    tbl.push_back(mk(0, '0,      0, 0, 0, 1, 0, INST_RR, 0, 0, 0, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      cmd_valid = v.cv; cmd_inst = v.ci; rsp_ready = v.rr; err_clr = v.ec;
      bus.imo_req_ack = v.ack; bus.imo_resp_valid = v.rv; bus.imo_resp_data = DATA_A5;
      tick();
      chk($sformatf("v%0d.req_valid", i), bus.imo_req_valid, v.e_req);
      if (v.e_req) chk($sformatf("v%0d.req_inst", i), bus.imo_req_inst, v.e_inst);
      chk($sformatf("v%0d.rsp_valid", i), rsp_valid, v.e_rsp);
      if (v.e_rsp) chk($sformatf("v%0d.rsp_data", i), rsp_data, v.e_rdata);
      chk($sformatf("v%0d.cmd_ready", i), cmd_ready, v.e_cr);
      chk($sformatf("v%0d.busy", i), busy, v.e_busy);
      chk($sformatf("v%0d.err_timeout", i), err_timeout, v.e_et);
      chk($sformatf("v%0d.err_unsol", i), err_unsolicited, v.e_eu);
      chk($sformatf("v%0d.cnt", i), issued_cnt, v.e_cnt);
    end
    cmd_valid = 0; rsp_ready = 0; err_clr = 0;
    bus.imo_req_ack = 0; bus.imo_resp_valid = 0;
    exp_cnt = 2;

    // Two DATA_RD with an interleaved CR_WR while the core withholds rsp_ready.
    push_cmd({4'h3, 124'hD1});
    push_cmd({4'h2, 124'hC2});
    push_cmd({4'h3, 124'hD2});
    ack_req({4'h3, 124'hD1}, "blk.d1");
    tick(); tick();
    bus.imo_resp_valid = 1; bus.imo_resp_data = DATA_X1;
    tick();
    bus.imo_resp_valid = 0;
    chk("blk.rsp1_valid", rsp_valid, 1'b1);
    chk("blk.rsp1_data", rsp_data, DATA_X1);
    ack_req({4'h2, 124'hC2}, "blk.cr");
    saw_req = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      saw_req |= bus.imo_req_valid;
    end
    chk("blk.d2_held", saw_req, 1'b0);
    chk("blk.rsp1_hold", rsp_valid, 1'b1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("blk.rsp1_clr", rsp_valid, 1'b0);
    ack_req({4'h3, 124'hD2}, "blk.d2");
    tick();
    bus.imo_resp_valid = 1; bus.imo_resp_data = DATA_X2;
    tick();
    bus.imo_resp_valid = 0;
    chk("blk.rsp2_data", rsp_data, DATA_X2);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // Fill with ack withheld: the request register takes the first entry, so
    // the FIFO closes only after five accepted commands.
    for (int i = 0; i < 6; i++) f[i] = {4'h4, 124'(i + 16'hF0)};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fill.ready%0d", i), cmd_ready, 1'b1);
      push_cmd(f[i]);
    end
    chk("fill.full", cmd_ready, 1'b0);
    chk("fill.head_inst", bus.imo_req_inst, f[0]);
    cmd_valid = 1; cmd_inst = f[5];
    tick(); tick();
    chk("fill.still_full", cmd_ready, 1'b0);
    bus.imo_req_ack = 1;
    tick();
    bus.imo_req_ack = 0;
    exp_cnt++;
    for (int n = 0; n < 10 && !cmd_ready; n++) tick();
    chk("fill.reopen", cmd_ready, 1'b1);
    tick();
    cmd_valid = 0;
    for (int i = 1; i < 6; i++) ack_req(f[i], $sformatf("fill.order%0d", i));
    tick();
    bus.imo_req_ack = 1;
    tick();
    bus.imo_req_ack = 0;
    chk("stray_ack.cnt", issued_cnt, exp_cnt);
    chk("stray_ack.busy", busy, 1'b0);

    // Timeout with TIMEOUT_CYC=16, then a late response and sticky-flag clearing.
    push_cmd({4'h1, 124'hAB});
    ack_req({4'h1, 124'hAB}, "tmo.rr");
    repeat (15) tick();
    chk("tmo.not_yet", err_timeout, 1'b0);
    chk("tmo.busy_wait", busy, 1'b1);
    tick();
    chk("tmo.flag", err_timeout, 1'b1);
    chk("tmo.idle", busy, 1'b0);
    bus.imo_resp_valid = 1; bus.imo_resp_data = DATA_X1;
    tick();
    bus.imo_resp_valid = 0;
    chk("tmo.late_unsol", err_unsolicited, 1'b1);
    chk("tmo.late_no_rsp", rsp_valid, 1'b0);
    err_clr = 1;
    tick();
    chk("tmo.clr", {err_timeout, err_unsolicited}, 2'b00);
    bus.imo_resp_valid = 1;
    tick();
    bus.imo_resp_valid = 0; err_clr = 0;
    chk("tmo.clr_wins", err_unsolicited, 1'b0);

    // Ack and response in the same REQ cycle: response is unsolicited, ack counts.
    push_cmd({4'h3, 124'hE3});
    wait_req("same.req");
    bus.imo_req_ack = 1; bus.imo_resp_valid = 1; bus.imo_resp_data = DATA_X1;
    tick();
    bus.imo_req_ack = 0; bus.imo_resp_valid = 0;
    exp_cnt++;
    chk("same.cnt", issued_cnt, exp_cnt);
    chk("same.unsol", err_unsolicited, 1'b1);
    chk("same.no_rsp", rsp_valid, 1'b0);
    chk("same.waiting", busy, 1'b1);
    bus.imo_resp_valid = 1; bus.imo_resp_data = DATA_X2;
    tick();
    bus.imo_resp_valid = 0;
    chk("same.rsp_data", rsp_data, DATA_X2);
    rsp_ready = 1; err_clr = 1;
    tick();
    rsp_ready = 0; err_clr = 0;

    // Reset while in WAIT_RESP with a full FIFO and a sticky flag set.
    bus.imo_resp_valid = 1;
    tick();
    bus.imo_resp_valid = 0;
    push_cmd(INST_RR);
    ack_req(INST_RR, "rst2.rr");
    for (int i = 0; i < 4; i++) push_cmd(INST_CR);
    chk("rst2.pre_full", cmd_ready, 1'b0);
    chk("rst2.pre_busy", busy, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("rst2.async_ready", cmd_ready, 1'b1);
    chk("rst2.async_busy", busy, 1'b0);
    chk("rst2.async_req", bus.imo_req_valid, 1'b0);
    chk("rst2.async_rsp", rsp_valid, 1'b0);
    chk("rst2.async_unsol", err_unsolicited, 1'b0);
    chk("rst2.async_cnt", issued_cnt, 32'd0);
    tick();
    rst_n = 1;
    tick();
    chk("rst2.after_cnt", issued_cnt, 32'd0);
    chk("rst2.after_busy", busy, 1'b0);
    chk("rst2.after_req", bus.imo_req_valid, 1'b0);
    exp_cnt = 0;
    push_cmd(INST_CR);
    ack_req(INST_CR, "rst2.fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
